lib_allocator_islip: RTL and testbench

LIB_ALLOCATOR_ISLIP -- requirements
Module: lib_allocator_islip

---
 rtl/lib_allocator_islip.sv | 136 +++++++++++++
 tb/tb_lib_allocator_islip.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lib_allocator_islip.sv
// iSLIP separable allocator: N requesters, M resources, up to ITER request-grant-accept rounds.
// Optional early exit on an iteration that adds no matches: define LIB_ISLIP_EARLY_EXIT_EN.
module lib_allocator_islip #(
  parameter int N    = 4,
  parameter int M    = 4,
  parameter int ITER = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   i_start,
  input  logic [0:N-1][0:M-1]    i_request,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [0:M-1][0:N-1]    o_grant
);

  localparam int NW = (N > 1) ? $clog2(N) : 1;
  localparam int MW = (M > 1) ? $clog2(M) : 1;
  localparam int IW = $clog2(ITER + 1);

  typedef enum logic [1:0] {S_IDLE, S_ITERATE, S_DONE} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [0:N-1][0:M-1] r_req;
  logic [0:M-1][0:N-1] r_grant;
  logic [NW-1:0]       r_gptr [M];
  logic [MW-1:0]       r_aptr [N];
  logic [IW-1:0]       r_iter;

  logic [N-1:0]        w_in_free;
  logic [M-1:0]        w_out_free;
  logic [0:M-1][0:N-1] w_gnt;
  logic [0:M-1][0:N-1] w_acc;
  logic                w_last;
  logic                w_exit;

  // One request-grant-accept round over the still-unmatched inputs and outputs.
  always_comb begin
    logic found;
    int   idx;
    found      = 1'b0;
    idx        = 0;
    w_out_free = '1;
    w_in_free  = '1;
    w_gnt      = '0;
    w_acc      = '0;
    for (int m = 0; m < M; m++) begin
      for (int n = 0; n < N; n++) begin
        if (r_grant[m][n]) begin
          w_out_free[m] = 1'b0;
          w_in_free[n]  = 1'b0;
        end
      end
    end
    for (int m = 0; m < M; m++) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        idx = int'(r_gptr[m]) + k;
        if (idx >= N) idx = idx - N;
        if (w_out_free[m] && !found && r_req[idx][m] && w_in_free[idx]) begin
          w_gnt[m][idx] = 1'b1;
          found         = 1'b1;
        end
      end
    end
    for (int n = 0; n < N; n++) begin
      found = 1'b0;
      for (int k = 0; k < M; k++) begin
        idx = int'(r_aptr[n]) + k;
        if (idx >= M) idx = idx - M;
        if (w_in_free[n] && !found && w_gnt[idx][n]) begin
          w_acc[idx][n] = 1'b1;
          found         = 1'b1;
        end
      end
    end
  end

  assign w_last = (r_iter == IW'(ITER));

`ifdef LIB_ISLIP_EARLY_EXIT_EN
  assign w_exit = w_last | ~(|w_acc);
`else
  assign w_exit = w_last;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (i_start) w_next = S_ITERATE;
      S_ITERATE: if (w_exit)  w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_req   <= '0;
      r_grant <= '0;
      r_iter  <= '0;
      for (int m = 0; m < M; m++) r_gptr[m] <= '0;
      for (int n = 0; n < N; n++) r_aptr[n] <= '0;
    end else begin
      if (r_state == S_IDLE && i_start) begin
        r_req   <= i_request;
        r_grant <= '0;
        r_iter  <= IW'(1);
      end
      if (r_state == S_ITERATE) begin
        r_grant <= r_grant | w_acc;
        if (!w_exit) r_iter <= r_iter + 1'b1;
      end
      // Pointers only move on first-iteration accepts; that is what desynchronises them.
      for (int m = 0; m < M; m++) begin
        for (int n = 0; n < N; n++) begin
          if (r_state == S_ITERATE && r_iter == IW'(1) && w_acc[m][n]) begin
            r_gptr[m] <= NW'((n + 1) % N);
            r_aptr[n] <= MW'((m + 1) % M);
          end
        end
      end
    end
  end

  assign o_busy  = (r_state == S_ITERATE);
  assign o_done  = (r_state == S_DONE);
  assign o_grant = r_grant;

endmodule

// File: tb/tb_lib_allocator_islip.sv
// Scoreboard bench for lib_allocator_islip: directed scenarios plus random request matrices
// checked against a list-based iSLIP reference model.
module tb_lib_allocator_islip;

  localparam int N    = 4;
  localparam int M    = 4;
  localparam int ITER = 3;
`ifdef LIB_ISLIP_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  typedef logic [0:N-1][0:M-1] mat_t;

  logic clk;
  logic reset_n;
  logic i_start;
  mat_t i_request;
  logic o_busy;
  logic o_done;
  mat_t o_grant;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   gp [M];
  int   ap [N];
  mat_t q_g [$];
  int   q_t [$];

  lib_allocator_islip #(.N(N), .M(M), .ITER(ITER)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_start   (i_start),
    .i_request (i_request),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_grant   (o_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  // Reference: matches kept as partner lists; pointers live in gp/ap across calls.
  function automatic void model(input mat_t req, output mat_t g, output int iters);
    int in_m [N];
    int out_m [M];
    int gr [M];
    int acc [N];
    int added;
    int c;
    g = '0;
    iters = 0;
    for (int i = 0; i < N; i++) in_m[i] = -1;
    for (int i = 0; i < M; i++) out_m[i] = -1;
    for (int it = 1; it <= ITER; it++) begin
      iters = it;
      added = 0;
      for (int m = 0; m < M; m++) begin
        gr[m] = -1;
        if (out_m[m] < 0) begin
          for (int k = 0; k < N; k++) begin
            c = (gp[m] + k) % N;
            if (in_m[c] < 0 && req[c][m]) begin
              gr[m] = c;
              break;
            end
          end
        end
      end
      for (int n = 0; n < N; n++) begin
        acc[n] = -1;
        if (in_m[n] < 0) begin
          for (int k = 0; k < M; k++) begin
            c = (ap[n] + k) % M;
            if (gr[c] == n) begin
              acc[n] = c;
              break;
            end
          end
        end
      end
      for (int n = 0; n < N; n++) begin
        if (acc[n] >= 0) begin
          c = acc[n];
          in_m[n]  = c;
          out_m[c] = n;
          g[c][n]  = 1'b1;
          added++;
          if (it == 1) begin
            gp[c] = (n + 1) % N;
            ap[n] = (c + 1) % M;
          end
        end
      end
      if (EE && added == 0) break;
    end
  endfunction

  function automatic bit onehot_ok(input mat_t g);
    int cnt;
    onehot_ok = 1'b1;
    for (int m = 0; m < M; m++) if ($countones(g[m]) > 1) onehot_ok = 1'b0;
    for (int n = 0; n < N; n++) begin
      cnt = 0;
      for (int m = 0; m < M; m++) cnt += int'(g[m][n]);
      if (cnt > 1) onehot_ok = 1'b0;
    end
  endfunction

  // Monitor: every o_done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (o_done) begin
      if (q_g.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 expected no pulse at cycle %0d", cyc);
      end else begin
        chk("grant", o_grant, q_g.pop_front());
        chk("done_cycle", cyc, q_t.pop_front());
      end
      chk("onehot", onehot_ok(o_grant), 1);
    end
  end

  task automatic wait_done();
    int cnt = 0;
    while (!o_done && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    if (!o_done) begin
      n_chk++;
      n_err++;
      $display("FAIL done_timeout: got no done expected done within 20 cycles at cycle %0d", cyc);
    end
  endtask

  task automatic do_alloc(input mat_t req, input bit poke, output mat_t got, output int lat);
    mat_t eg;
    int   it;
    int   t0;
    i_request = req;
    i_start   = 1'b1;
    model(req, eg, it);
    t0 = cyc + 1;
    q_g.push_back(eg);
    q_t.push_back(t0 + it);
    @(negedge clk);
    i_start   = 1'b0;
    i_request = 16'($urandom);
    chk("busy_after_start", o_busy, 1);
    if (poke && it >= 2) begin
      i_start = 1'b1;
      @(negedge clk);
      i_start = 1'b0;
    end
    wait_done();
    got = o_grant;
    lat = cyc - t0;
    @(negedge clk);
    chk("idle_busy", o_busy, 0);
    chk("single_done", o_done, 0);
    chk("grant_hold", o_grant, eg);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000 time units");
    $fatal(1);
  end

  initial begin
    mat_t g;
    mat_t g2;
    mat_t r;
    int   l;
    int   it1;
    int   it2;
    int   t0;
    for (int i = 0; i < M; i++) gp[i] = 0;
    for (int i = 0; i < N; i++) ap[i] = 0;
    i_start   = 1'b0;
    i_request = '0;
    reset_n   = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    chk("reset_busy", o_busy, 0);
    chk("reset_done", o_done, 0);
    chk("reset_grant", o_grant, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    do_alloc(16'hFFFF, 1'b0, g, l);
    chk("s1_grant", g, 16'h8420);
    chk("s1_latency", l, 3);

    do_alloc(16'hFFFF, 1'b0, g, l);
    chk("s2_grant", g, 16'h4821);
    chk("s2_latency", l, 3);

    r = '0;
    r[2][3] = 1'b1;
    do_alloc(r, 1'b0, g, l);
    chk("s3_row3", g[3], 4'b0010);
    chk("s3_latency", l, EE ? 2 : 3);

    do_alloc('0, 1'b0, g, l);
    chk("s4_grant", g, 0);
    chk("s4_latency", l, EE ? 1 : 3);

    // Abort during iteration 2; the pending allocation never completes.
    i_request = 16'hFFFF;
    i_start   = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("s5_busy", o_busy, 0);
    chk("s5_done", o_done, 0);
    chk("s5_grant", o_grant, 0);
    for (int i = 0; i < M; i++) gp[i] = 0;
    for (int i = 0; i < N; i++) ap[i] = 0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    do_alloc(16'hFFFF, 1'b0, g, l);
    chk("s5_rerun_grant", g, 16'h8420);
    chk("s5_rerun_latency", l, 3);

    // i_start held high: back-to-back allocations separated by one IDLE cycle.
    i_request = 16'hFFFF;
    i_start   = 1'b1;
    t0 = cyc + 1;
    model(16'hFFFF, g, it1);
    q_g.push_back(g);
    q_t.push_back(t0 + it1);
    model(16'hFFFF, g2, it2);
    q_g.push_back(g2);
    q_t.push_back(t0 + it1 + 2 + it2);
    @(negedge clk);
    wait_done();
    @(negedge clk);
    chk("s6_gap_done", o_done, 0);
    chk("s6_gap_busy", o_busy, 0);
    wait_done();
    i_start = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 2))
        0:       r = 16'($urandom);
        1:       r = 16'($urandom) & 16'($urandom);
        default: r = 16'($urandom) | 16'($urandom);
      endcase
      do_alloc(r, 1'($urandom_range(0, 1)), g, l);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", q_g.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
